// File: rtl/alu_pkg.sv
// Shared op_code encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MUL_BUSY = 2'b01,
    ST_DONE     = 2'b10
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial-product step per cycle, WIDTH steps per product.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               running;
  logic               last;

  // Next accumulator value and last-step detect; product is exposed one step early
  // so the top can register it on the same edge as the final iteration.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
    last    = running && (cnt == CW'(WIDTH - 1));
    done    = last;
    product = acc_next;
  end

  // Operand load on start, then one shift-add iteration per cycle until WIDTH steps are done.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last) begin
        running <= 1'b0;
      end else begin
        running <= 1'b1;
      end
    end else begin
      running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU (AND/OR/ADD single-cycle, MUL multi-cycle) with valid/ready in and out.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               c_out,
  output logic               zero,
  output logic               busy
);

  state_t             state;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] alu_res;
  logic               alu_carry;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  // Single-cycle result for the logic ops and ADD, selected from the live inputs.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_code)
      OP_AND: alu_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:  alu_res = {{WIDTH{1'b0}}, a | b};
      OP_ADD: begin
        alu_res   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        alu_carry = sum[WIDTH];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  assign mul_start = (state == ST_IDLE) && in_ready && in_valid && (op_code == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM with registered handshake flags and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out       <= '0;
      c_out     <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (op_code == OP_MUL) begin
              busy  <= 1'b1;
              state <= ST_MUL_BUSY;
            end else begin
              out       <= alu_res;
              c_out     <= alu_carry;
              zero      <= (alu_res == '0);
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_MUL_BUSY: begin
          if (mul_done) begin
            out       <= mul_product;
            c_out     <= 1'b0;
            zero      <= (mul_product == '0);
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            busy <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 and WIDTH=4.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv8, ir8, ov8, ordy8, c8, z8, busy8;
  logic [7:0]  a8, b8;
  logic [1:0]  op8;
  logic [15:0] out8;

  logic        iv4, ir4, ov4, ordy4, c4, z4, busy4;
  logic [3:0]  a4, b4;
  logic [1:0]  op4;
  logic [7:0]  out4;

  int n_chk  = 0;
  int n_pass = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .op_code(op8), .out_valid(ov8), .out_ready(ordy8), .out(out8),
    .c_out(c8), .zero(z8), .busy(busy8)
  );

  alu_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .op_code(op4), .out_valid(ov4), .out_ready(ordy4), .out(out4),
    .c_out(c4), .zero(z4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run8(input string tag, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] eo, input logic ec, input logic ez, input int elat);
    int lat;
    logic busy_ok;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(ir8), 32'd1);
    iv8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(negedge clk);
    iv8 = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!ov8 && lat < 40) begin
      if (!(busy8 && !ir8)) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    if (op == OP_MUL) check({tag, " busy"}, 32'(busy_ok), 32'd1);
    check({tag, " out"}, 32'(out8), 32'(eo));
    check({tag, " c_out"}, 32'(c8), 32'(ec));
    check({tag, " zero"}, 32'(z8), 32'(ez));
    ordy8 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0;
    check({tag, " drop"}, {30'd0, ov8, ir8}, 32'd1);
    check({tag, " hold"}, 32'(out8), 32'(eo));
  endtask

  task automatic run4(input string tag, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] eo, input logic ec, input logic ez, input int elat);
    int lat;
    @(negedge clk);
    iv4 = 1'b1; op4 = op; a4 = a; b4 = b;
    @(negedge clk);
    iv4 = 1'b0;
    lat = 1;
    while (!ov4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " out"}, 32'(out4), 32'(eo));
    check({tag, " c_out"}, 32'(c4), 32'(ec));
    check({tag, " zero"}, 32'(z4), 32'(ez));
    ordy4 = 1'b1;
    @(negedge clk);
    ordy4 = 1'b0;
    check({tag, " drop"}, {30'd0, ov4, ir4}, 32'd1);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    iv8 = 1'b0; ordy8 = 1'b0; a8 = 8'h00; b8 = 8'h00; op8 = 2'b00;
    iv4 = 1'b0; ordy4 = 1'b0; a4 = 4'h0; b4 = 4'h0; op4 = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset flags", {26'd0, ir8, ov8, c8, z8, busy8, 1'b0}, 32'h20);
    check("reset out", 32'(out8), 32'h0);

    run8("and", OP_AND, 8'h0F, 8'h3C, 16'h000C, 1'b0, 1'b0, 1);
    run8("add_wrap", OP_ADD, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1, 1);
    run8("add_small", OP_ADD, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 1);
    run8("mul_ff", OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 9);
    run8("mul_0f", OP_MUL, 8'h0F, 8'h01, 16'h000F, 1'b0, 1'b0, 9);

    // Backpressure: OR result held while out_ready stays low and a new request is offered.
    @(negedge clk);
    iv8 = 1'b1; op8 = OP_OR; a8 = 8'hA0; b8 = 8'h05;
    @(negedge clk);
    op8 = OP_AND; a8 = 8'h00; b8 = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check("bp out", 32'(out8), 32'h00A5);
      check("bp flags", {30'd0, ov8, ir8}, 32'd2);
      @(negedge clk);
    end
    iv8 = 1'b0;
    ordy8 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0;
    check("bp release", {30'd0, ov8, ir8}, 32'd1);
    @(negedge clk);
    check("bp no ghost", {30'd0, ov8, ir8}, 32'd1);
    check("bp out kept", 32'(out8), 32'h00A5);

    // Abort a multiply after three busy cycles.
    iv8 = 1'b1; op8 = OP_MUL; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (2) @(negedge clk);
    check("abort busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort state", {29'd0, ir8, ov8, busy8}, 32'd4);
    check("abort out", 32'(out8), 32'h0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (ov8) pulses++;
      @(negedge clk);
    end
    check("abort no valid", 32'(pulses), 32'd0);
    run8("add_after", OP_ADD, 8'h10, 8'h20, 16'h0030, 1'b0, 1'b0, 1);

    run4("w4_mul", OP_MUL, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0, 5);
    run4("w4_add", OP_ADD, 4'h8, 4'h8, 8'h00, 1'b1, 1'b1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, clocked successor to the 8-bit combinational ALU. It supports the same four operations (AND, OR, ADD, MUL) at generic width WIDTH. Operands enter through a valid/ready handshake, and results leave through a second handshake. MUL is a multi-cycle shift-add engine instead of a combinational array. The block sits between the operand/op_code source and the result consumer in the datapath.

Parameters:
- WIDTH, 8, operand width in bits (legal values >= 2); the result is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and op_code are valid this cycle
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op_code  input  2  operation select: 00 AND, 01 OR, 10 ADD, 11 MUL
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result this cycle
- out  output  2*WIDTH  result
- c_out  output  1  carry out; meaningful for ADD only
- zero  output  1  out == 0
- busy  output  1  a MUL is in progress

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready 1, out_valid 0, out 0, c_out 0, zero 0, busy 0.
- States:
  - IDLE: in_ready = 1.
  - MUL_BUSY: in_ready = 0, busy = 1.
  - DONE: in_ready = 0, out_valid = 1.
- Accept: an operation is accepted when in_valid && in_ready in IDLE; a, b and op_code are captured on that edge.
- Op_code 00/01/10: result is registered and the block goes IDLE->DONE. out_valid rises on the cycle after the accept (latency 1).
- Op_code 11: the block goes IDLE->MUL_BUSY. It loads the multiplicand (zero-extended to 2*WIDTH), the multiplier and accumulator = 0, and clears the counter.
  - Each MUL_BUSY cycle: if the multiplier LSB is 1, the accumulator adds the multiplicand. Then the multiplicand shifts left by 1, the multiplier shifts right by 1, and the counter increments.
  - After exactly WIDTH iterations the block goes to DONE. out_valid rises WIDTH+1 cycles after the accept.
- Width rules:
  - AND/OR: the low WIDTH bits hold a&b or a|b; the upper WIDTH bits are 0; c_out = 0.
  - ADD: out[WIDTH-1:0] = (a+b) mod 2^WIDTH; upper bits are 0; c_out = carry out of bit WIDTH-1.
  - MUL: full unsigned 2*WIDTH product; no overflow is possible; c_out = 0.
  - zero = (out == 0) for every op and is registered together with out.
- DONE: out, c_out and zero are held stable while out_ready = 0.
  - On out_valid && out_ready the block goes to IDLE. out_valid falls next cycle; out, c_out and zero keep their last values.
  - Any in_valid asserted during MUL_BUSY or DONE is ignored; the source must hold it until in_ready.
- Back-to-back: maximum throughput is one op per 2 cycles for AND/OR/ADD and one per WIDTH+2 cycles for MUL.
- Reset mid-operation: rst in any state aborts the operation in the next cycle, discards any partial product, and no out_valid pulse is produced. Reset has priority over all handshakes.
- The counter is $clog2(WIDTH+1) bits wide and does not wrap during normal operation.

Decomposition:
- Shared package alu_pkg:
  - op_code localparams OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_MUL=2'b11
  - state encoding ST_IDLE, ST_MUL_BUSY, ST_DONE
- One sub-module, alu_mul_seq: the shift-add multiplier datapath, parametrised by WIDTH.
  - Inputs: start, a, b.
  - Outputs: done pulse, product.
  - The top-level FSM, handshakes and logic ops stay in alu_seq.

Test Plan:
- WIDTH=8, AND a=8'h0F b=8'h3C -> out=16'h000C, c_out=0, zero=0, out_valid 1 cycle after the accept.
- ADD a=8'hFF b=8'h01 -> out=16'h0000, c_out=1, zero=1. ADD 8'h01+8'h01 -> out=16'h0002, c_out=0.
- MUL a=8'hFF b=8'hFF -> out=16'hFE01, out_valid exactly 9 cycles after the accept, busy=1 and in_ready=0 throughout. MUL 8'h0F*8'h01 -> 16'h000F.
- Backpressure: complete OR a=8'hA0 b=8'h05 with out_ready=0 for 5 cycles -> out=16'h00A5 held stable, in_ready=0, a new in_valid is ignored. After the out_ready handshake, in_ready=1 next cycle.
- Reset after 3 MUL_BUSY cycles -> no out_valid pulse, in_ready=1 and out=0 after reset. A following ADD 8'h10+8'h20 -> 16'h0030.
- WIDTH=4 instance, MUL 4'hF*4'hF -> out=8'hE1 after 5 cycles. ADD 4'h8+4'h8 -> out=8'h00, c_out=1, zero=1.
